regfile_writeback_arbiter: RTL and testbench

//   Write-side driver for the 32x32 register file: merges single-cycle ALU results and

---
 rtl/regfile_writeback_arbiter_pkg.sv | 18 +
 rtl/regfile_writeback_arbiter_fifo.sv | 64 ++++++
 rtl/regfile_writeback_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_writeback_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter and its LSU result FIFO.
package regfile_writeback_arbiter_pkg;

    localparam int WB_N       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_N-1:0]       data;
    } wb_entry_t;

    // x0 is hardwired to zero, so writes aimed at it must never reach the array.
    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] rd);
        return rd == X0;
    endfunction

endpackage

// File: rtl/regfile_writeback_arbiter_fifo.sv
// Small synchronous FIFO that queues LSU results until the write port is free.
module wb_sync_fifo
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wb_entry_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  T                           push_data_i,
    input  logic                       pop_i,
    output T                           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T                mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage carries no reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Merges ALU and queued LSU results onto the single register-file write port.
// Optional same-cycle forwarding to decode is enabled by defining WB_FORWARD_EN.
module regfile_writeback_arbiter
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int N            = WB_N,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid_i,
    input  logic [REG_ADDR_W-1:0]      alu_rd_i,
    input  logic [N-1:0]               alu_data_i,
    output logic                       alu_stall_o,
    input  logic                       lsu_valid_i,
    output logic                       lsu_ready_o,
    input  logic [REG_ADDR_W-1:0]      lsu_rd_i,
    input  logic [N-1:0]               lsu_data_i,
    output logic                       Reg_Write_o,
    output logic [REG_ADDR_W-1:0]      Write_Register_o,
    output logic [N-1:0]               Write_Data_o,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
`ifdef WB_FORWARD_EN
    ,
    input  logic [REG_ADDR_W-1:0]      fwd_rs1_i,
    input  logic [REG_ADDR_W-1:0]      fwd_rs2_i,
    output logic                       fwd_rs1_hit_o,
    output logic                       fwd_rs2_hit_o,
    output logic [N-1:0]               fwd_data_o1,
    output logic [N-1:0]               fwd_data_o2
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [N-1:0]          data;
    } entry_t;

    entry_t                fifo_head;
    entry_t                lsu_entry;
    entry_t                win;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  lsu_accept;
    logic                  issue;
    logic                  bypass;
    logic [SW-1:0]         starve_d;
    logic [SW-1:0]         starve_q;
    logic                  stall_d;
    logic                  stall_q;
    logic                  reg_write_q;
    logic [REG_ADDR_W-1:0] wr_reg_q;
    logic [N-1:0]          wr_data_q;

    assign lsu_entry   = '{rd: lsu_rd_i, data: lsu_data_i};
    assign lsu_ready_o = !fifo_full;
    assign lsu_accept  = lsu_valid_i && !fifo_full;

    wb_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (lsu_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count_o)
    );

    // Forced drain beats ALU; otherwise ALU beats the queue, and the queue beats a fresh LSU result.
    always_comb begin
        issue    = 1'b0;
        fifo_pop = 1'b0;
        bypass   = 1'b0;
        win      = '0;
        starve_d = '0;
        if (stall_q) begin
            if (!fifo_empty) begin
                issue    = 1'b1;
                fifo_pop = 1'b1;
                win      = fifo_head;
            end
        end else if (alu_valid_i) begin
            issue    = 1'b1;
            win      = '{rd: alu_rd_i, data: alu_data_i};
            starve_d = fifo_empty ? '0 : starve_q + SW'(1);
        end else if (!fifo_empty) begin
            issue    = 1'b1;
            fifo_pop = 1'b1;
            win      = fifo_head;
        end else if (lsu_accept) begin
            issue    = 1'b1;
            bypass   = 1'b1;
            win      = lsu_entry;
        end
        fifo_push = lsu_accept && !bypass;
        stall_d   = (starve_d == SW'(STARVE_LIMIT));
    end

    // Address and data hold on idle cycles so downstream sees stable values.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
            starve_q    <= '0;
            stall_q     <= 1'b0;
        end else begin
            reg_write_q <= issue && !is_x0(win.rd);
            if (issue) begin
                wr_reg_q  <= win.rd;
                wr_data_q <= win.data;
            end
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign alu_stall_o      = stall_q;
    assign Reg_Write_o      = reg_write_q;
    assign Write_Register_o = wr_reg_q;
    assign Write_Data_o     = wr_data_q;

`ifdef WB_FORWARD_EN
    assign fwd_rs1_hit_o = reg_write_q && (wr_reg_q == fwd_rs1_i) && !is_x0(fwd_rs1_i);
    assign fwd_rs2_hit_o = reg_write_q && (wr_reg_q == fwd_rs2_i) && !is_x0(fwd_rs2_i);
    assign fwd_data_o1   = wr_data_q;
    assign fwd_data_o2   = wr_data_q;
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter against a queue-based reference model.
module tb_regfile_writeback_arbiter;

   localparam int N     = 32;
   localparam int DEPTH = 4;
   localparam int LIMIT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid_i;
   logic [4:0]  alu_rd_i;
   logic [31:0] alu_data_i;
   logic        alu_stall_o;
   logic        lsu_valid_i;
   logic        lsu_ready_o;
   logic [4:0]  lsu_rd_i;
   logic [31:0] lsu_data_i;
   logic        Reg_Write_o;
   logic [4:0]  Write_Register_o;
   logic [31:0] Write_Data_o;
   logic [2:0]  fifo_count_o;
   logic [42:0] obs;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   int          m_starve;
   bit          m_stall;
   bit          m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;

   regfile_writeback_arbiter #(.N(N), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk              (clk),
      .reset            (reset),
      .alu_valid_i      (alu_valid_i),
      .alu_rd_i         (alu_rd_i),
      .alu_data_i       (alu_data_i),
      .alu_stall_o      (alu_stall_o),
      .lsu_valid_i      (lsu_valid_i),
      .lsu_ready_o      (lsu_ready_o),
      .lsu_rd_i         (lsu_rd_i),
      .lsu_data_i       (lsu_data_i),
      .Reg_Write_o      (Reg_Write_o),
      .Write_Register_o (Write_Register_o),
      .Write_Data_o     (Write_Data_o),
      .fifo_count_o     (fifo_count_o)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   assign obs = {Reg_Write_o, Write_Register_o, Write_Data_o, alu_stall_o, lsu_ready_o, fifo_count_o};

   function automatic logic [42:0] expv();
      return {m_we, m_wa, m_wd, m_stall, (mq.size() < DEPTH), 3'(mq.size())};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_starve = 0;
      m_stall  = 0;
      m_we     = 0;
      m_wa     = '0;
      m_wd     = '0;
   endtask

   // One clock of the write-port rules, applied to the queue with the inputs now on the pins.
   task automatic model_step();
      bit   ready;
      bit   acc;
      bit   issued;
      bit   byp;
      ent_t w;
      ent_t l;
      ready  = (mq.size() < DEPTH);
      acc    = lsu_valid_i && ready;
      issued = 0;
      byp    = 0;
      l.rd   = lsu_rd_i;
      l.data = lsu_data_i;
      w.rd   = '0;
      w.data = '0;
      if (reset) begin
         model_reset();
         return;
      end
      if (m_stall) begin
         m_starve = 0;
         if (mq.size() > 0) begin
            w = mq.pop_front();
            issued = 1;
         end
      end else if (alu_valid_i) begin
         w.rd = alu_rd_i;
         w.data = alu_data_i;
         issued = 1;
         m_starve = (mq.size() > 0) ? m_starve + 1 : 0;
      end else if (mq.size() > 0) begin
         w = mq.pop_front();
         issued = 1;
         m_starve = 0;
      end else if (acc) begin
         w = l;
         issued = 1;
         byp = 1;
      end
      if (acc && !byp) mq.push_back(l);
      m_stall = (m_starve == LIMIT);
      if (issued) begin
         m_we = (w.rd != 0);
         m_wa = w.rd;
         m_wd = w.data;
      end else begin
         m_we = 0;
      end
   endtask

   task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
      alu_valid_i = av;
      alu_rd_i    = ard;
      alu_data_i  = ad;
      lsu_valid_i = lv;
      lsu_rd_i    = lrd;
      lsu_data_i  = ld;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      reset = 1'b0;
      checks++;
      if (obs !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd0}) begin
         errors++;
         $display("[TB] FAIL reset_state: got %h expected %h", obs, {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'd0});
      end
      tick();
      checks++;
      if (obs !== expv()) begin
         errors++;
         $display("[TB] FAIL reset_idle: got %h expected %h", obs, expv());
      end
   endtask

   task automatic test_alu_single();
      drive(1, 5'd5, 32'h1234, 0, 0, 0);
      tick();
      checks++;
      if ({Reg_Write_o, Write_Register_o, Write_Data_o} !== {1'b1, 5'd5, 32'h1234}) begin
         errors++;
         $display("[TB] FAIL alu_write: got we=%0b rd=%0d data=%h expected we=1 rd=5 data=00001234",
                  Reg_Write_o, Write_Register_o, Write_Data_o);
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if ({Reg_Write_o, Write_Register_o, Write_Data_o} !== {1'b0, 5'd5, 32'h1234}) begin
         errors++;
         $display("[TB] FAIL idle_hold: got we=%0b rd=%0d data=%h expected we=0 rd=5 data=00001234",
                  Reg_Write_o, Write_Register_o, Write_Data_o);
      end
   endtask

   task automatic test_lsu_bypass();
      drive(0, 0, 0, 1, 5'd7, 32'hAA);
      tick();
      checks++;
      if ({Reg_Write_o, Write_Register_o, Write_Data_o, fifo_count_o} !== {1'b1, 5'd7, 32'hAA, 3'd0}) begin
         errors++;
         $display("[TB] FAIL lsu_bypass: got we=%0b rd=%0d data=%h count=%0d expected we=1 rd=7 data=000000aa count=0",
                  Reg_Write_o, Write_Register_o, Write_Data_o, fifo_count_o);
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if (obs !== expv()) begin
         errors++;
         $display("[TB] FAIL bypass_idle: got %h expected %h", obs, expv());
      end
   endtask

   task automatic test_starvation();
      for (int c = 1; c <= 12; c++) begin
         if (!alu_stall_o) begin
            alu_valid_i = 1'b1;
            alu_rd_i    = 5'(10 + c);
            alu_data_i  = 32'hA000 + 32'(c);
         end
         lsu_valid_i = (c <= 4);
         lsu_rd_i    = 5'(20 + c);
         lsu_data_i  = 32'hB000 + 32'(c);
         tick();
         checks++;
         if (obs !== expv()) begin
            errors++;
            $display("[TB] FAIL starve_cycle%0d: got %h expected %h", c, obs, expv());
         end
         if (c == 4) begin
            checks++;
            if ({alu_stall_o, lsu_ready_o, fifo_count_o} !== {1'b1, 1'b0, 3'd4}) begin
               errors++;
               $display("[TB] FAIL starve_full: got stall=%0b ready=%0b count=%0d expected stall=1 ready=0 count=4",
                        alu_stall_o, lsu_ready_o, fifo_count_o);
            end
         end
         if (c == 5) begin
            checks++;
            if ({Reg_Write_o, Write_Register_o, Write_Data_o, alu_stall_o, fifo_count_o} !==
                {1'b1, 5'd21, 32'hB001, 1'b0, 3'd3}) begin
               errors++;
               $display("[TB] FAIL forced_drain: got we=%0b rd=%0d data=%h stall=%0b count=%0d expected we=1 rd=21 data=0000b001 stall=0 count=3",
                        Reg_Write_o, Write_Register_o, Write_Data_o, alu_stall_o, fifo_count_o);
            end
         end
      end
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (obs !== expv()) begin
            errors++;
            $display("[TB] FAIL drain_cycle%0d: got %h expected %h", i, obs, expv());
         end
         if (mq.size() == 0 && !alu_stall_o) break;
      end
      checks++;
      if (fifo_count_o !== 3'd0) begin
         errors++;
         $display("[TB] FAIL drain_empty: got count=%0d expected count=0", fifo_count_o);
      end
   endtask

   task automatic test_rd_zero();
      drive(1, 5'd3, 32'h33, 1, 5'd9, 32'h99);
      tick();
      drive(1, 5'd0, 32'hFFFF, 0, 0, 0);
      tick();
      checks++;
      if ({Reg_Write_o, Write_Register_o, Write_Data_o, fifo_count_o} !== {1'b0, 5'd0, 32'hFFFF, 3'd1}) begin
         errors++;
         $display("[TB] FAIL rd_zero: got we=%0b rd=%0d data=%h count=%0d expected we=0 rd=0 data=0000ffff count=1",
                  Reg_Write_o, Write_Register_o, Write_Data_o, fifo_count_o);
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if ({Reg_Write_o, Write_Register_o, Write_Data_o, fifo_count_o} !== {1'b1, 5'd9, 32'h99, 3'd0}) begin
         errors++;
         $display("[TB] FAIL rd_zero_queue: got we=%0b rd=%0d data=%h count=%0d expected we=1 rd=9 data=00000099 count=0",
                  Reg_Write_o, Write_Register_o, Write_Data_o, fifo_count_o);
      end
   endtask

   task automatic test_reset_midstream();
      for (int c = 0; c < 3; c++) begin
         drive(1, 5'(11 + c), 32'hC000 + 32'(c), 1, 5'(14 + c), 32'hD000 + 32'(c));
         tick();
      end
      checks++;
      if (fifo_count_o !== 3'd3) begin
         errors++;
         $display("[TB] FAIL mid_fill: got count=%0d expected count=3", fifo_count_o);
      end
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;
      checks++;
      if ({fifo_count_o, Reg_Write_o, alu_stall_o} !== {3'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL mid_reset: got count=%0d we=%0b stall=%0b expected count=0 we=0 stall=0",
                  fifo_count_o, Reg_Write_o, alu_stall_o);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (Reg_Write_o !== 1'b0 || obs !== expv()) begin
            errors++;
            $display("[TB] FAIL mid_dropped%0d: got %h expected %h", i, obs, expv());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 59) == 0);
         if (!alu_stall_o) begin
            alu_valid_i = ($urandom_range(0, 9) < 6);
            alu_rd_i    = 5'($urandom_range(0, 31));
            alu_data_i  = $urandom;
         end
         lsu_valid_i = ($urandom_range(0, 9) < 5);
         lsu_rd_i    = 5'($urandom_range(0, 31));
         lsu_data_i  = $urandom;
         tick();
         checks++;
         if (obs !== expv()) begin
            errors++;
            $display("[TB] FAIL random%0d: got %h expected %h", i, obs, expv());
         end
      end
      reset = 1'b0;
   endtask

   // Runs every directed test, then the randomized comparison, then reports the tally.
   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      test_reset();
      test_alu_single();
      test_lsu_bypass();
      test_starvation();
      test_rd_zero();
      test_reset_midstream();
      test_random();
      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Guards against a hung simulation.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors + 1);
      $fatal(1, "[TB] timeout");
   end

endmodule
